// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for fetch_queue.
// The master modport is the fetch/decode pipeline side; the slave modport is the queue itself.
interface fetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    logic                           push_F;
    logic [DATA_W-1:0]              instr_F;
    logic [DATA_W-1:0]              pcplus4_F;
    logic                           stall_D;
    logic                           flush_D;
    logic [DATA_W-1:0]              instr_D;
    logic [DATA_W-1:0]              pcplus4_D;
    logic                           valid_D;
    logic                           full_F;
    logic [$clog2(DEPTH+1)-1:0]     count_F;

    modport master (
        output push_F, instr_F, pcplus4_F, stall_D, flush_D,
        input  instr_D, pcplus4_D, valid_D, full_F, count_F
    );

    modport slave (
        input  push_F, instr_F, pcplus4_F, stall_D, flush_D,
        output instr_D, pcplus4_D, valid_D, full_F, count_F
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode, feeding a registered decode stage.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue pass a pushed word straight to decode.
module fetch_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    fetch_queue_if.slave    bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_memInstr [DEPTH];
    logic [DATA_W-1:0] r_memPc    [DEPTH];
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_instrD;
    logic [DATA_W-1:0] r_pcD;
    logic              r_validD;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = bus.push_F && w_empty && !bus.stall_D && !bus.flush_D;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word goes to decode only, so it must not also be enqueued.
    assign w_push = bus.push_F && !w_full && !bus.flush_D && !w_bypass;
    assign w_pop  = !w_empty && !bus.stall_D && !bus.flush_D;

    // Storage has no reset: stale entries are never read because the count gates every pop.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memInstr[r_wrPtr] <= bus.instr_F;
            r_memPc[r_wrPtr]    <= bus.pcplus4_F;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (bus.flush_D) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Decode register: flush beats stall; otherwise queue head, then bypass word, then bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instrD <= '0;
            r_pcD    <= '0;
            r_validD <= 1'b0;
        end else if (bus.flush_D) begin
            r_instrD <= '0;
            r_pcD    <= '0;
            r_validD <= 1'b0;
        end else if (!bus.stall_D) begin
            if (w_pop) begin
                r_instrD <= r_memInstr[r_rdPtr];
                r_pcD    <= r_memPc[r_rdPtr];
                r_validD <= 1'b1;
            end else if (w_bypass) begin
                r_instrD <= bus.instr_F;
                r_pcD    <= bus.pcplus4_F;
                r_validD <= 1'b1;
            end else begin
                r_instrD <= '0;
                r_pcD    <= '0;
                r_validD <= 1'b0;
            end
        end
    end

    assign bus.instr_D   = r_instrD;
    assign bus.pcplus4_D = r_pcD;
    assign bus.valid_D   = r_validD;
    assign bus.full_F    = w_full;
    assign bus.count_F   = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_queue;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk;
    logic reset;
    int   testCount;
    int   failCount;

    logic [63:0] modelQ [$];
    logic [31:0] modelInstr;
    logic [31:0] modelPc;
    logic        modelValid;

    fetch_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fqIf ();

    fetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fqIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, required %0h", tag, observed, expected);
        end
    endtask

    task automatic modelClear();
        modelQ.delete();
        modelInstr = '0;
        modelPc    = '0;
        modelValid = 1'b0;
    endtask

    // Behavioural view of one clock edge: a FIFO feeding a decode register, decided on pre-edge occupancy.
    task automatic modelStep(input logic push, input logic [31:0] instr, input logic [31:0] pc,
                             input logic stall, input logic flush);
        bit wasFull;
        bit bypass;
        bit bypassEn;
        logic [63:0] head;
        if (flush) begin
            modelClear();
            return;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        bypassEn = 1'b1;
`else
        bypassEn = 1'b0;
`endif
        wasFull = (modelQ.size() == DEPTH);
        bypass  = bypassEn && push && !stall && (modelQ.size() == 0);
        if (!stall) begin
            if (modelQ.size() > 0) begin
                head       = modelQ.pop_front();
                modelInstr = head[63:32];
                modelPc    = head[31:0];
                modelValid = 1'b1;
            end else if (bypass) begin
                modelInstr = instr;
                modelPc    = pc;
                modelValid = 1'b1;
            end else begin
                modelInstr = '0;
                modelPc    = '0;
                modelValid = 1'b0;
            end
        end
        if (push && !wasFull && !bypass) modelQ.push_back({instr, pc});
    endtask

    task automatic compareModel(input string tag);
        checkOutput({tag, ".instr_D"},   64'(fqIf.instr_D),   64'(modelInstr));
        checkOutput({tag, ".pcplus4_D"}, 64'(fqIf.pcplus4_D), 64'(modelPc));
        checkOutput({tag, ".valid_D"},   64'(fqIf.valid_D),   64'(modelValid));
        checkOutput({tag, ".count_F"},   64'(fqIf.count_F),   64'(modelQ.size()));
        checkOutput({tag, ".full_F"},    64'(fqIf.full_F),    64'(modelQ.size() == DEPTH));
    endtask

    task automatic applyStimulus(input string tag, input logic push, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic stall, input logic flush);
        fqIf.push_F    = push;
        fqIf.instr_F   = instr;
        fqIf.pcplus4_F = pc;
        fqIf.stall_D   = stall;
        fqIf.flush_D   = flush;
        @(posedge clk);
        modelStep(push, instr, pc, stall, flush);
        #1;
        compareModel(tag);
    endtask

    task automatic doReset();
        reset = 1'b1;
        fqIf.push_F = 1'b0;
        fqIf.instr_F = '0;
        fqIf.pcplus4_F = '0;
        fqIf.stall_D = 1'b0;
        fqIf.flush_D = 1'b0;
        modelClear();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic firstPushCheck(input string tag);
        applyStimulus({tag, ".e1"}, 1'b1, 32'h2008_0005, 32'h4, 1'b0, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        checkOutput({tag, ".e1_instr"}, 64'(fqIf.instr_D), 64'h2008_0005);
        checkOutput({tag, ".e1_valid"}, 64'(fqIf.valid_D), 64'd1);
`else
        checkOutput({tag, ".e1_count"}, 64'(fqIf.count_F), 64'd1);
        checkOutput({tag, ".e1_valid"}, 64'(fqIf.valid_D), 64'd0);
        applyStimulus({tag, ".e2"}, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput({tag, ".e2_instr"}, 64'(fqIf.instr_D), 64'h2008_0005);
        checkOutput({tag, ".e2_pc"},    64'(fqIf.pcplus4_D), 64'h4);
`endif
    endtask

    initial begin
        int guard;
        testCount = 0;
        failCount = 0;
        reset = 1'b0;
        doReset();
        compareModel("reset");
        checkOutput("reset.full_F", 64'(fqIf.full_F), 64'd0);

        firstPushCheck("first_push");

        // Overfill while decode is stalled, then drain in order.
        doReset();
        for (int i = 0; i <= DEPTH; i++)
            applyStimulus("fill", 1'b1, 32'hA000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'b1, 1'b0);
        checkOutput("fill.full_F", 64'(fqIf.full_F), 64'd1);
        checkOutput("fill.count_F", 64'(fqIf.count_F), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            checkOutput("drain.order", 64'(fqIf.instr_D), 64'(32'hA000_0000 + 32'(i)));
        end
        applyStimulus("drain_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("drain_empty.valid", 64'(fqIf.valid_D), 64'd0);

        // Steady push+pop at occupancy 2 across pointer wrap.
        doReset();
        applyStimulus("wrap_pre", 1'b1, 32'hB000_0000, 32'h200, 1'b1, 1'b0);
        applyStimulus("wrap_pre", 1'b1, 32'hB000_0001, 32'h204, 1'b1, 1'b0);
        for (int i = 2; i < 12; i++) begin
            applyStimulus("wrap", 1'b1, 32'hB000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
            checkOutput("wrap.count", 64'(fqIf.count_F), 64'd2);
            checkOutput("wrap.order", 64'(fqIf.instr_D), 64'(32'hB000_0000 + 32'(i - 2)));
        end

        // Flush wins over stall and push.
        doReset();
        for (int i = 0; i < 3; i++)
            applyStimulus("flush_pre", 1'b1, 32'hC000_0000 + 32'(i), 32'h300, 1'b1, 1'b0);
        applyStimulus("flush", 1'b1, 32'hDEAD_BEEF, 32'h400, 1'b1, 1'b1);
        checkOutput("flush.count", 64'(fqIf.count_F), 64'd0);
        checkOutput("flush.valid", 64'(fqIf.valid_D), 64'd0);
        checkOutput("flush.instr", 64'(fqIf.instr_D), 64'd0);
        applyStimulus("flush_post", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("flush_post.absent", 64'(fqIf.valid_D), 64'd0);

        // Asynchronous reset between edges with 3 queued and a valid decode word.
        doReset();
        applyStimulus("areset_pre", 1'b1, 32'hE000_0000, 32'h500, 1'b0, 1'b0);
        applyStimulus("areset_pre", 1'b1, 32'hE000_0001, 32'h504, 1'b0, 1'b0);
        guard = 0;
        while (modelQ.size() < 3 && guard < 6) begin
            applyStimulus("areset_pre", 1'b1, 32'hE000_0010 + 32'(guard), 32'h510, 1'b1, 1'b0);
            guard++;
        end
        checkOutput("areset_pre.count", 64'(fqIf.count_F), 64'd3);
        checkOutput("areset_pre.valid", 64'(fqIf.valid_D), 64'd1);
        fqIf.push_F = 1'b0;
        #2;
        reset = 1'b1;
        modelClear();
        #1;
        checkOutput("areset.instr", 64'(fqIf.instr_D), 64'd0);
        checkOutput("areset.valid", 64'(fqIf.valid_D), 64'd0);
        checkOutput("areset.count", 64'(fqIf.count_F), 64'd0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        compareModel("areset_idle");
        firstPushCheck("areset_push");

        // Random traffic against the model.
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 99) < 60),
                          $urandom, $urandom,
                          ($urandom_range(0, 99) < 35),
                          ($urandom_range(0, 99) < 4));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
